wbu: RTL and testbench
======================

Name: wbu

Overview:
- Write-back stage and architectural register file of the single-issue core. Sits directly downstream of the execute stage and consumes its registered write-back bundle (rd enable, rd index, rd data).
- Commits results into a 2^RAW x DW register file and serves the decode stage's two combinational source-operand reads, with write-through bypass.
- Keeps a retired-instruction counter for the CSR unit. The CSR unit can overwrite that counter.

Parameters:
RAW, 5, register index width (2^RAW registers, x0 hardwired zero)
DW, 32, register data width
CNTW, 64, retired-instruction counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
i_holding  input  1  pipeline stall from LSU; no commit while high
i_wb_valid  input  1  execute output register holds a live instruction (cleared by flush)
i_wb_rd_en  input  1  instruction writes rd
i_wb_rd  input  RAW  destination index
i_wb_rd_data  input  DW  result data
i_rs_1  input  RAW  decode read index 1
i_rs_2  input  RAW  decode read index 2
o_rs_1_data  output  DW  read data 1 (combinational)
o_rs_2_data  output  DW  read data 2 (combinational)
i_dbg_addr  input  RAW  debug/trace read index
o_dbg_data  output  DW  debug read data (combinational, no bypass)
i_instret_we  input  1  CSR write strobe for counter
i_instret_wdata  input  CNTW  CSR write value
o_instret  output  CNTW  retired-instruction count (registered)

Behaviour:
- Reset is synchronous: when rst=1 at a rising edge, all 2^RAW registers and o_instret become 0. Reset wins over every other event in the same cycle, including a commit or a CSR write.
- Commit: commit = i_wb_valid & ~i_holding. This is evaluated every cycle. A held bundle therefore retires exactly once, in its first cycle with i_holding=0.
- Register write:
  - On commit & i_wb_rd_en & (i_wb_rd != 0), regfile[i_wb_rd] <= i_wb_rd_data at the next rising edge.
  - Writes to x0 are discarded. x0 always reads 0.
- Read port n (n=1,2):
  - If i_rs_n == 0, the output is 0.
  - Otherwise, if commit & i_wb_rd_en & i_wb_rd == i_rs_n, the output is i_wb_rd_data (write-through bypass in the same cycle).
  - Otherwise, the output is regfile[i_rs_n].
  - Purely combinational, zero latency.
- Debug port: o_dbg_data = regfile[i_dbg_addr], with 0 for index 0. No bypass; a new value becomes visible the cycle after the write.
- Retire counter:
  - If i_instret_we, o_instret <= i_instret_wdata. The CSR write has priority, and a coincident commit is not counted.
  - Else if commit, o_instret <= o_instret + 1. The counter wraps modulo 2^CNTW: all-ones goes to 0.
  - A commit with i_wb_rd_en=0 (branch, store) still increments the counter.
- Stall: while i_holding=1 there is no register write and no count. Bypass is also inactive, because bypass is gated by commit.
- Flush: i_wb_valid=0 means no commit, no write and no count, regardless of i_wb_rd_en.
- Reset mid-stall or mid-bundle: the pending bundle is dropped and never counted.
- Both read ports may address the same register, with or without bypass; both outputs must be identical.
- Implementation: flop array of 2^RAW-1 entries (x0 not stored). No X on any output after reset.

Test Plan:
- Reset, then drive i_rs_1=5, i_rs_2=0, i_dbg_addr=5 -> o_rs_1_data=0, o_rs_2_data=0, o_dbg_data=0, o_instret=0.
- Commit rd=5, data=0xDEADBEEF with i_rs_1=5 in the same cycle:
  - -> o_rs_1_data=0xDEADBEEF that cycle (bypass).
  - -> o_dbg_data=0xDEADBEEF only from the next cycle.
  - -> o_instret=1.
- Commit rd=0, data=0x1234 -> x0 still reads 0 on all ports; o_instret increments by 1.
- i_wb_valid=1, rd=7, data=0x55, with i_holding=1 for 3 cycles then 0:
  - -> no bypass and x7 unchanged during the hold.
  - -> x7=0x55 and o_instret +1 exactly once after release.
- CSR counter write:
  - i_instret_we=1, wdata=0xFFFF_FFFF_FFFF_FFFF together with a commit -> o_instret=all-ones (commit not counted).
  - A following commit -> o_instret=0 (wrap).
- i_wb_valid=0 with i_wb_rd_en=1, rd=3, data=0x99 -> x3 unchanged, o_instret unchanged. Then assert rst together with a valid commit to rd=3 -> x3=0, o_instret=0.

Source files
------------

// File: rtl/wbu.sv
// Write-back stage: architectural register file (x0 hardwired zero) with
// write-through bypass on both decode read ports, plus the retired-instruction counter.
module wbu #(
   parameter int RAW  = 5,
   parameter int DW   = 32,
   parameter int CNTW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_holding,
   input  logic            i_wb_valid,
   input  logic            i_wb_rd_en,
   input  logic [RAW-1:0]  i_wb_rd,
   input  logic [DW-1:0]   i_wb_rd_data,
   input  logic [RAW-1:0]  i_rs_1,
   input  logic [RAW-1:0]  i_rs_2,
   output logic [DW-1:0]   o_rs_1_data,
   output logic [DW-1:0]   o_rs_2_data,
   input  logic [RAW-1:0]  i_dbg_addr,
   output logic [DW-1:0]   o_dbg_data,
   input  logic            i_instret_we,
   input  logic [CNTW-1:0] i_instret_wdata,
   output logic [CNTW-1:0] o_instret
);

   localparam int NREG = 2 ** RAW;

   // x0 is not stored; entries 1..NREG-1 only
   logic [DW-1:0]   regs_q [1:NREG-1];
   logic [CNTW-1:0] instret_q;
   logic [CNTW-1:0] instret_d;
   logic            commit_s;
   logic            wr_en_s;
   logic [DW-1:0]   rs_1_data_s;
   logic [DW-1:0]   rs_2_data_s;
   logic [DW-1:0]   dbg_data_s;

   assign commit_s = i_wb_valid & ~i_holding;
   assign wr_en_s  = commit_s & i_wb_rd_en & (i_wb_rd != {RAW{1'b0}});

   // Stored-state read; index 0 never matches and falls through to zero.
   function automatic logic [DW-1:0] rf_read(input logic [RAW-1:0] idx);
      logic [DW-1:0] val;
      val = {DW{1'b0}};
      for (int k = 1; k < NREG; k++) begin
         if (idx == RAW'(k)) begin
            val = regs_q[k];
         end
      end
      return val;
   endfunction

   function automatic logic [DW-1:0] bypass_read(input logic [RAW-1:0] idx);
      logic [DW-1:0] val;
      if (idx == {RAW{1'b0}}) begin
         val = {DW{1'b0}};
      end else if (commit_s && i_wb_rd_en && (i_wb_rd == idx)) begin
         val = i_wb_rd_data;
      end else begin
         val = rf_read(idx);
      end
      return val;
   endfunction

   // Register file storage: reset clears every entry, commit writes rd.
   always_ff @(posedge clk) begin
      for (int k = 1; k < NREG; k++) begin
         if (rst) begin
            regs_q[k] <= {DW{1'b0}};
         end else if (wr_en_s && (i_wb_rd == RAW'(k))) begin
            regs_q[k] <= i_wb_rd_data;
         end
      end
   end

   // Read ports: decode ports see the in-flight commit, debug port does not.
   always_comb begin
      rs_1_data_s = bypass_read(i_rs_1);
      rs_2_data_s = bypass_read(i_rs_2);
      dbg_data_s  = rf_read(i_dbg_addr);
   end

   assign o_rs_1_data = rs_1_data_s;
   assign o_rs_2_data = rs_2_data_s;
   assign o_dbg_data  = dbg_data_s;

   // Retire counter next state: CSR write beats a coincident commit.
   always_comb begin
      instret_d = instret_q;
      if (i_instret_we) begin
         instret_d = i_instret_wdata;
      end else if (commit_s) begin
         instret_d = instret_q + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
         instret_d = instret_q;
      end
   end

   // Retire counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= {CNTW{1'b0}};
      end else begin
         instret_q <= instret_d;
      end
   end

   assign o_instret = instret_q;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: a behavioural register-file/counter model checked
// every negedge, plus hand-computed literal expectations from directed vectors.
module tb_wbu;

   logic        clk;
   logic        rst;
   logic        i_holding;
   logic        i_wb_valid;
   logic        i_wb_rd_en;
   logic [4:0]  i_wb_rd;
   logic [31:0] i_wb_rd_data;
   logic [4:0]  i_rs_1;
   logic [4:0]  i_rs_2;
   logic [31:0] o_rs_1_data;
   logic [31:0] o_rs_2_data;
   logic [4:0]  i_dbg_addr;
   logic [31:0] o_dbg_data;
   logic        i_instret_we;
   logic [63:0] i_instret_wdata;
   logic [63:0] o_instret;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_rf [0:31];
   logic [63:0] m_cnt;

   wbu dut (
      .clk(clk), .rst(rst), .i_holding(i_holding), .i_wb_valid(i_wb_valid),
      .i_wb_rd_en(i_wb_rd_en), .i_wb_rd(i_wb_rd), .i_wb_rd_data(i_wb_rd_data),
      .i_rs_1(i_rs_1), .i_rs_2(i_rs_2), .o_rs_1_data(o_rs_1_data),
      .o_rs_2_data(o_rs_2_data), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
      .i_instret_we(i_instret_we), .i_instret_wdata(i_instret_wdata),
      .o_instret(o_instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model read: zero for x0, the committing result if it targets idx, else stored value.
   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (i_wb_valid && !i_holding && i_wb_rd_en && i_wb_rd == idx) return i_wb_rd_data;
      return m_rf[idx];
   endfunction

   // Model state update at each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
         m_cnt <= 64'd0;
      end else begin
         if (i_wb_valid && !i_holding && i_wb_rd_en && i_wb_rd != 5'd0)
            m_rf[i_wb_rd] <= i_wb_rd_data;
         if (i_instret_we) m_cnt <= i_instret_wdata;
         else if (i_wb_valid && !i_holding) m_cnt <= m_cnt + 64'd1;
      end
   end

   // Compare DUT against model every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_rs1", {32'd0, o_rs_1_data}, {32'd0, model_read(i_rs_1)});
         cmp("m_rs2", {32'd0, o_rs_2_data}, {32'd0, model_read(i_rs_2)});
         cmp("m_dbg", {32'd0, o_dbg_data}, {32'd0, (i_dbg_addr == 5'd0) ? 32'd0 : m_rf[i_dbg_addr]});
         cmp("m_instret", o_instret, m_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bundle(input logic v, input logic en, input logic [4:0] rd, input logic [31:0] d);
      i_wb_valid   = v;
      i_wb_rd_en   = en;
      i_wb_rd      = rd;
      i_wb_rd_data = d;
   endtask

   initial begin
      rst = 1'b1; i_holding = 1'b0; bundle(1'b0, 1'b0, 5'd0, 32'd0);
      i_rs_1 = 5'd5; i_rs_2 = 5'd0; i_dbg_addr = 5'd5;
      i_instret_we = 1'b0; i_instret_wdata = 64'd0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      cmp("rst_rs1", {32'd0, o_rs_1_data}, 64'd0);
      cmp("rst_rs2", {32'd0, o_rs_2_data}, 64'd0);
      cmp("rst_dbg", {32'd0, o_dbg_data}, 64'd0);
      cmp("rst_instret", o_instret, 64'd0);

      // Commit x5 with bypass on both ports
      step(); bundle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF); i_rs_2 = 5'd5;
      @(negedge clk);
      cmp("byp_rs1", {32'd0, o_rs_1_data}, 64'h0000_0000_DEAD_BEEF);
      cmp("byp_rs2", {32'd0, o_rs_2_data}, 64'h0000_0000_DEAD_BEEF);
      cmp("byp_dbg_old", {32'd0, o_dbg_data}, 64'd0);
      step(); bundle(1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      cmp("wr_dbg", {32'd0, o_dbg_data}, 64'h0000_0000_DEAD_BEEF);
      cmp("wr_instret", o_instret, 64'd1);

      // Write to x0 is discarded but counted
      step(); bundle(1'b1, 1'b1, 5'd0, 32'h1234); i_rs_1 = 5'd0; i_rs_2 = 5'd0; i_dbg_addr = 5'd0;
      @(negedge clk);
      cmp("x0_rs1", {32'd0, o_rs_1_data}, 64'd0);
      step(); bundle(1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      cmp("x0_dbg", {32'd0, o_dbg_data}, 64'd0);
      cmp("x0_instret", o_instret, 64'd2);

      // Held bundle to x7 retires once, after release
      step(); bundle(1'b1, 1'b1, 5'd7, 32'h55); i_holding = 1'b1; i_rs_1 = 5'd7; i_dbg_addr = 5'd7;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cmp("hold_rs1", {32'd0, o_rs_1_data}, 64'd0);
         cmp("hold_instret", o_instret, 64'd2);
         if (c < 2) step();
      end
      step(); i_holding = 1'b0;
      @(negedge clk);
      cmp("rel_byp", {32'd0, o_rs_1_data}, 64'h55);
      step(); bundle(1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      cmp("rel_dbg", {32'd0, o_dbg_data}, 64'h55);
      cmp("rel_instret", o_instret, 64'd3);

      // CSR write beats commit, then wrap
      step(); bundle(1'b1, 1'b1, 5'd9, 32'h1); i_instret_we = 1'b1; i_instret_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step(); i_instret_we = 1'b0; bundle(1'b1, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      cmp("csr_wr", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
      step(); bundle(1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      cmp("wrap", o_instret, 64'd0);

      // Flushed bundle to x3, then reset with a live commit
      step(); bundle(1'b0, 1'b1, 5'd3, 32'h99); i_rs_1 = 5'd3; i_dbg_addr = 5'd3;
      @(negedge clk);
      cmp("flush_rs1", {32'd0, o_rs_1_data}, 64'd0);
      step();
      @(negedge clk);
      cmp("flush_dbg", {32'd0, o_dbg_data}, 64'd0);
      cmp("flush_instret", o_instret, 64'd0);
      rst = 1'b1; bundle(1'b1, 1'b1, 5'd3, 32'h99);
      step(); rst = 1'b0; bundle(1'b0, 1'b0, 5'd0, 32'd0); i_rs_1 = 5'd5; i_rs_2 = 5'd7;
      @(negedge clk);
      cmp("rst_x3", {32'd0, o_dbg_data}, 64'd0);
      cmp("rst_x5", {32'd0, o_rs_1_data}, 64'd0);
      cmp("rst_x7", {32'd0, o_rs_2_data}, 64'd0);
      cmp("rst_cnt", o_instret, 64'd0);

      // Mixed traffic checked by the model only
      for (int c = 0; c < 60; c++) begin
         step();
         bundle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom);
         i_holding    = ($urandom_range(0, 3) == 0);
         i_rs_1       = 5'($urandom_range(0, 7));
         i_rs_2       = ($urandom_range(0, 1) == 1) ? i_rs_1 : 5'($urandom_range(0, 7));
         i_dbg_addr   = 5'($urandom_range(0, 7));
         i_instret_we = ($urandom_range(0, 15) == 0);
         i_instret_wdata = {$urandom, $urandom};
      end
      step();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
